// File: rtl/fifo_ram_ctrl.sv
// Pointer/flag controller that turns a dual-port simple RAM into a first-word-fall-through FIFO.
// Define FIFO_CTRL_LEVEL_EN to add the occupancy counter (level) and a registered almost_full flag.
module fifo_ram_ctrl #(
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  full,
   output logic                  empty
`ifdef FIFO_CTRL_LEVEL_EN
   ,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  almost_full
`endif
);

   logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
   logic                  full_reg, full_next;
   logic                  empty_reg, empty_next;
   logic                  push_ok, pop_ok;

   // A push into a full FIFO is fine when a pop frees the head slot on the same edge.
   always_comb begin
      push_ok = wr & (~full_reg | rd) & ~reset;
      pop_ok  = rd & ~empty_reg & ~reset;
   end

   always_comb begin
      wr_ptr_next = push_ok ? wr_ptr_reg + ADDR_WIDTH'(1) : wr_ptr_reg;
      rd_ptr_next = pop_ok  ? rd_ptr_reg + ADDR_WIDTH'(1) : rd_ptr_reg;
      full_next   = full_reg;
      empty_next  = empty_reg;
      case ({push_ok, pop_ok})
         2'b10: begin
            empty_next = 1'b0;
            full_next  = (wr_ptr_next == rd_ptr_reg);
         end
         2'b01: begin
            full_next  = 1'b0;
            empty_next = (rd_ptr_next == wr_ptr_reg);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         full_reg   <= full_next;
         empty_reg  <= empty_next;
      end
   end

   // The RAM registers r_addr itself, so presenting the next read pointer keeps q on the head.
   assign we     = push_ok;
   assign w_addr = wr_ptr_reg;
   assign r_addr = rd_ptr_next;
   assign full   = full_reg;
   assign empty  = empty_reg;

`ifdef FIFO_CTRL_LEVEL_EN
   localparam int                DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH + 1)'(DEPTH - 1);

   logic [ADDR_WIDTH:0] level_reg, level_next;
   logic                almost_full_reg;

   always_comb begin
      level_next = level_reg;
      case ({push_ok, pop_ok})
         2'b10:   level_next = level_reg + (ADDR_WIDTH + 1)'(1);
         2'b01:   level_next = level_reg - (ADDR_WIDTH + 1)'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_reg       <= '0;
         almost_full_reg <= 1'b0;
      end else begin
         level_reg       <= level_next;
         almost_full_reg <= (level_next >= AF_THRESH);
      end
   end

   assign level       = level_reg;
   assign almost_full = almost_full_reg;
`endif

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Directed bench: fifo_ram_ctrl driving an 8-bit, 8-entry RAM model with registered read address.
// Level/almost_full checks are included when FIFO_CTRL_LEVEL_EN is defined.
module tb_fifo_ram_ctrl;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset, wr, rd;
   logic [7:0]    d;
   logic          we, full, empty;
   logic [AW-1:0] w_addr, r_addr;
`ifdef FIFO_CTRL_LEVEL_EN
   logic [AW:0]   level;
   logic          almost_full;
`endif

   logic [7:0]    mem [0:7];
   logic [AW-1:0] addr_reg;
   logic [7:0]    q;
   logic [7:0]    model [$];
   logic [7:0]    exp_q [0:7];

   int checks = 0;
   int errors = 0;

   fifo_ram_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .wr(wr), .rd(rd), .we(we),
      .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty)
`ifdef FIFO_CTRL_LEVEL_EN
      , .level(level), .almost_full(almost_full)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (we) mem[w_addr] <= d;
      addr_reg <= r_addr;
   end
   assign q = mem[addr_reg];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic w, input logic r, input logic [7:0] dv);
      wr = w; rd = r; d = dv;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      wr = 1'b0; rd = 1'b0; d = 8'h00;
   endtask

   initial begin
      reset = 1'b1; wr = 1'b1; rd = 1'b0; d = 8'hEE;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_we", we, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_waddr", w_addr, 0);
      chk("rst_raddr", r_addr, 0);
`ifdef FIFO_CTRL_LEVEL_EN
      chk("rst_level", level, 0);
      chk("rst_af", almost_full, 0);
`endif
      wr = 1'b0; reset = 1'b0;
      #1;

      // Reset mid-traffic after three pushes
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 8'(i + 1));
         tick();
      end
      chk("pre_rst_waddr", w_addr, 3);
      chk("pre_rst_empty", empty, 0);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_waddr", w_addr, 0);
      chk("mid_rst_raddr", r_addr, 0);
      #1 reset = 1'b0;

      // FWFT: pushed word visible on q the cycle after the push, no rd
      drive(1, 0, 8'hA5);
      tick();
      chk("fwft_empty", empty, 0);
      chk("fwft_q", q, 8'hA5);
      drive(0, 1, 8'h00);
      tick();
      chk("fwft_pop_empty", empty, 1);

      // Fill from pointer 1
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 8'(8'h10 + i));
         chk($sformatf("fill_we_%0d", i), we, 1);
         chk($sformatf("fill_full_pre_%0d", i), full, 0);
         tick();
`ifdef FIFO_CTRL_LEVEL_EN
         chk($sformatf("fill_level_%0d", i), level, i + 1);
         chk($sformatf("fill_af_%0d", i), almost_full, (i + 1 >= 7) ? 1 : 0);
`endif
      end
      chk("fill_full", full, 1);
      chk("fill_empty", empty, 0);
      chk("fill_q_head", q, 8'h10);

      drive(1, 0, 8'hFF);
      chk("full_wr_we", we, 0);
      tick();
      chk("full_wr_full", full, 1);
      chk("full_wr_waddr", w_addr, 1);
      chk("full_wr_q", q, 8'h10);

      // Simultaneous push/pop while full
      drive(1, 1, 8'h5A);
      chk("sim_full_we", we, 1);
      chk("sim_full_q_old", q, 8'h10);
      tick();
      chk("sim_full_full", full, 1);
      chk("sim_full_q_new", q, 8'h11);
`ifdef FIFO_CTRL_LEVEL_EN
      chk("sim_full_level", level, 8);
`endif
      for (int j = 0; j < 7; j++) exp_q[j] = 8'(8'h11 + j);
      exp_q[7] = 8'h5A;
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("drain_q_%0d", j), q, exp_q[j]);
         drive(0, 1, 8'h00);
         tick();
      end
      chk("drain_empty", empty, 1);
      chk("drain_full", full, 0);
      drive(0, 1, 8'h00);
      tick();
      chk("rd_empty_hold", empty, 1);
      chk("rd_empty_raddr", r_addr, 2);

      // Simultaneous push/pop while empty: push only
      drive(1, 1, 8'h33);
      chk("sim_empty_we", we, 1);
      tick();
      chk("sim_empty_empty", empty, 0);
      chk("sim_empty_q", q, 8'h33);
`ifdef FIFO_CTRL_LEVEL_EN
      chk("sim_empty_level", level, 1);
      chk("sim_empty_af", almost_full, 0);
`endif
      drive(0, 1, 8'h00);
      tick();
      chk("sim_empty_drain", empty, 1);

      // Wrap: mixed push/pop keeping occupancy between 1 and 3
      drive(1, 0, 8'h40);
      tick();
      model.push_back(8'h40);
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("wrap_q_%0d", i), q, model[0]);
         case (i % 3)
            0: begin
               drive(1, 0, 8'(8'h50 + i));
               model.push_back(8'(8'h50 + i));
            end
            1: begin
               drive(0, 1, 8'h00);
               void'(model.pop_front());
            end
            default: begin
               drive(1, 1, 8'(8'h50 + i));
               void'(model.pop_front());
               model.push_back(8'(8'h50 + i));
            end
         endcase
         tick();
         chk($sformatf("wrap_empty_%0d", i), empty, 0);
         chk($sformatf("wrap_full_%0d", i), full, 0);
      end
      while (model.size() > 0) begin
         chk("wrap_drain_q", q, model[0]);
         void'(model.pop_front());
         drive(0, 1, 8'h00);
         tick();
      end
      chk("wrap_final_empty", empty, 1);
      chk("wrap_final_ptrs", w_addr, r_addr);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
